temp_table_writer: RTL and testbench

//  Fills a temperature-conversion lookup table into a writable RAM, one entry per address.

---
 rtl/temp_table_writer.sv | 154 +++++++++++++++
 tb/tb_temp_table_writer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/temp_table_writer.sv
// Builds a C->F / F->C temperature lookup table into a write-only RAM port,
// computing each entry with an iterative restoring divider. Optional TABLE_CSUM_EN adds csum.
module temp_table_writer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
`ifdef TABLE_CSUM_EN
  ,output logic [15:0]      csum
`endif
);

  localparam int NW = ADDR_W + 4;
  localparam int CW = $clog2(NW + 1);
  localparam logic [ADDR_W-1:0] A_LAST  = '1;
  localparam logic [31:0]       SAT_MAX = (32'd1 << DATA_W) - 32'd1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_WRITE, S_FIN} state_t;

  state_t            st_q, st_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [NW-1:0]     n_q, n_d;
  logic [NW-1:0]     q_q, q_d;
  logic [3:0]        r_q, r_d;
  logic [3:0]        dv_q, dv_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] res_q, res_d;
`ifdef TABLE_CSUM_EN
  logic [15:0]       csum_q, csum_d;
`endif

  // Numerators carry the rounding offset so a plain floor divide rounds to nearest.
  logic [NW-1:0] a_ext, f_off, n_cf, n_fc;
  assign a_ext = NW'(a_q);
  assign n_cf  = (a_ext << 3) + a_ext + NW'(2);
  assign f_off = a_ext - NW'(32);
  assign n_fc  = (a_ext <= NW'(32)) ? '0 : (f_off << 2) + f_off + NW'(4);

  logic [4:0]    trial, diff;
  logic          ge;
  logic [NW-1:0] q_nxt;
  logic [31:0]   biased, sat_v;
  assign trial  = {r_q, n_q[NW-1]};
  assign ge     = (trial >= {1'b0, dv_q});
  assign diff   = trial - {1'b0, dv_q};
  assign q_nxt  = {q_q[NW-2:0], ge};
  assign biased = 32'(q_nxt) + (mode_q ? 32'd32 : 32'd0);
  assign sat_v  = (biased > SAT_MAX) ? SAT_MAX : biased;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= S_IDLE;
      mode_q <= 1'b0;
      a_q    <= '0;
      n_q    <= '0;
      q_q    <= '0;
      r_q    <= '0;
      dv_q   <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
`ifdef TABLE_CSUM_EN
      csum_q <= '0;
`endif
    end else begin
      st_q   <= st_d;
      mode_q <= mode_d;
      a_q    <= a_d;
      n_q    <= n_d;
      q_q    <= q_d;
      r_q    <= r_d;
      dv_q   <= dv_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
`ifdef TABLE_CSUM_EN
      csum_q <= csum_d;
`endif
    end
  end

  always_comb begin
    st_d   = st_q;
    mode_d = mode_q;
    a_d    = a_q;
    n_d    = n_q;
    q_d    = q_q;
    r_d    = r_q;
    dv_d   = dv_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
`ifdef TABLE_CSUM_EN
    csum_d = csum_q;
`endif
    unique case (st_q)
      S_IDLE: if (start) begin
        mode_d = mode;
        a_d    = '0;
        st_d   = S_LOAD;
`ifdef TABLE_CSUM_EN
        csum_d = '0;
`endif
      end
      S_LOAD: begin
        n_d   = mode_q ? n_cf : n_fc;
        dv_d  = mode_q ? 4'd5 : 4'd9;
        q_d   = '0;
        r_d   = '0;
        cnt_d = '0;
        st_d  = S_DIV;
      end
      S_DIV: begin
        r_d   = ge ? diff[3:0] : trial[3:0];
        n_d   = n_q << 1;
        q_d   = q_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NW - 1)) begin
          res_d = sat_v[DATA_W-1:0];
          st_d  = S_WRITE;
        end
      end
      S_WRITE: if (wr_ready) begin
`ifdef TABLE_CSUM_EN
        csum_d = csum_q + 16'(res_q);
`endif
        if (a_q == A_LAST) st_d = S_FIN;
        else begin
          a_d  = a_q + 1'b1;
          st_d = S_LOAD;
        end
      end
      S_FIN:   st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  assign wr_en   = (st_q == S_WRITE);
  assign wr_addr = a_q;
  assign wr_data = res_q;
  assign busy    = (st_q == S_LOAD) || (st_q == S_DIV) || (st_q == S_WRITE);
  assign done    = (st_q == S_FIN);
`ifdef TABLE_CSUM_EN
  assign csum    = csum_q;
`endif

endmodule

// File: tb/tb_temp_table_writer.sv
// Bench for temp_table_writer: full-table passes against a rounding reference model,
// spec vector table, stall / reset / ignored-start corner cases, random wr_ready.
module tb_temp_table_writer;
  logic       clk = 1'b0;
  logic       reset, start, mode, wr_ready;
  logic       wr_en, busy, done;
  logic [7:0] wr_addr, wr_data;
`ifdef TABLE_CSUM_EN
  logic [15:0] csum;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int log_a[$];
  int log_d[$];
  int obs[0:1][0:255];
  int done_cyc;

  typedef struct { int m; int addr; int exp; } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  temp_table_writer #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done)
`ifdef TABLE_CSUM_EN
    , .csum(csum)
`endif
  );

  // Reference: round-to-nearest of the real conversion, clamped and saturated.
  function automatic int ref_entry(input int m, input int a);
    int v;
    if (m != 0)    v = (18 * a + 5) / 10 + 32;
    else if (a <= 32) v = 0;
    else           v = (10 * (a - 32) + 9) / 18;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // rmode: 0 ready always, 1 random ready, 2 stall addr 7 for 5 cycles.
  task automatic run_pass(input int m, input int rmode, input bit poke);
    int cyc, sc, sa, sd, esum;
    bit r, snap;
    log_a.delete(); log_d.delete();
    sc = 0; snap = 0; sa = 0; sd = 0;
    mode  = m[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 6000) begin
      if (poke && cyc == 100) begin start = 1'b1; mode = ~m[0]; end
      if (poke && cyc == 101) start = 1'b0;
      r = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rmode == 2 && wr_en && wr_addr == 8'd7) begin
        if (!snap) begin snap = 1; sa = int'(wr_addr); sd = int'(wr_data); end
        else begin
          chk("stall_wr_en", int'(wr_en), 1);
          chk("stall_addr", int'(wr_addr), sa);
          chk("stall_data", int'(wr_data), sd);
        end
        r = (sc >= 5);
        sc++;
      end
      wr_ready = r;
      if (wr_en && r) begin
        log_a.push_back(int'(wr_addr));
        log_d.push_back(int'(wr_data));
      end
      @(negedge clk);
      cyc++;
    end
    done_cyc = cyc;
    chk("done_seen", int'(done), 1);
    chk("busy_at_done", int'(busy), 0);
    chk("wr_en_at_done", int'(wr_en), 0);
    if (rmode == 2) chk("stall_cycles", sc, 6);
`ifdef TABLE_CSUM_EN
    esum = 0;
    for (int i = 0; i < 256; i++) esum = (esum + ref_entry(m, i)) % 65536;
    chk("csum", int'(csum), esum);
`endif
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse_1cyc", int'(done), 0);
    if (poke) begin
      @(negedge clk);
      chk("start_at_done_ignored", int'(busy), 0);
    end
    chk("n_writes", log_a.size(), 256);
    for (int i = 0; i < log_a.size(); i++) begin
      chk("addr_order", log_a[i], i);
      chk("entry_data", log_d[i], ref_entry(m, log_a[i]));
      if (log_a[i] >= 0 && log_a[i] < 256) obs[m][log_a[i]] = log_d[i];
    end
  endtask

  initial begin
    bit found;
    vecs[0] = '{1, 0, 32};   vecs[1] = '{1, 37, 99};  vecs[2] = '{1, 100, 212};
    vecs[3] = '{1, 124, 255}; vecs[4] = '{1, 125, 255};
    vecs[5] = '{0, 0, 0};    vecs[6] = '{0, 32, 0};   vecs[7] = '{0, 98, 37};
    vecs[8] = '{0, 212, 100}; vecs[9] = '{0, 255, 124};
    for (int i = 0; i < 2; i++) for (int j = 0; j < 256; j++) obs[i][j] = -1;

    reset = 1'b1; start = 1'b0; mode = 1'b0; wr_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    run_pass(1, 0, 0);
    chk("done_cycle", done_cyc, 3585);
    run_pass(0, 2, 0);
    for (int i = 0; i < 10; i++)
      chk($sformatf("vec_m%0d_a%0d", vecs[i].m, vecs[i].addr),
          obs[vecs[i].m][vecs[i].addr], vecs[i].exp);

    run_pass(1, 0, 1);

    // Abort mid-division at a=10, then rebuild from scratch.
    mode = 1'b1; start = 1'b1; wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      if (wr_addr == 8'd10 && busy && !wr_en) found = 1;
      else @(negedge clk);
    end
    chk("reach_a10", int'(found), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_wr_addr", int'(wr_addr), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_pass(0, 0, 0);

    repeat (2) run_pass(int'($urandom_range(0, 1)), 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
